// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the issue stage, register file and ROB:
// ROB index width, issue FSM encoding and the held-instruction record.
package issue_ctrl_pkg;

  localparam int ROB_BIT = 4;
  localparam int REG_W   = 5;
  localparam int XLEN    = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             wr_rd;
    logic             is_mem;
  } slot_t;

endpackage

// File: rtl/issue_slot.sv
// One-entry hold register for a decoded instruction waiting to issue.
// Clear wins over load; otherwise the contents are held.
module issue_slot
  import issue_ctrl_pkg::*;
(
  input  logic  clk_in,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);

  // NOTE: the slot is cleared synchronously like every other register here,
  // so a dropped instruction leaves no stale fields behind; non-blocking
  // assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: takes one decoded instruction per cycle and
// dispatches it to ROB plus RS or LSB once all targets have room.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,

  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [XLEN-1:0]    dec_inst,
  input  logic [XLEN-1:0]    dec_pc,
  input  logic [REG_W-1:0]   dec_rd,
  input  logic [REG_W-1:0]   dec_rs1,
  input  logic [REG_W-1:0]   dec_rs2,
  input  logic               dec_wr_rd,
  input  logic               dec_is_mem,

  output logic [REG_W-1:0]   get_id1,
  output logic [REG_W-1:0]   get_id2,
  input  logic [XLEN-1:0]    val1,
  input  logic [XLEN-1:0]    val2,
  input  logic               has_dep1,
  input  logic               has_dep2,
  input  logic [ROB_BIT-1:0] dep1,
  input  logic [ROB_BIT-1:0] dep2,

  output logic               rob_issue_reg,
  output logic [REG_W-1:0]   issue_reg_id,
  output logic [ROB_BIT-1:0] issue_rob_entry,

  input  logic               rob_full,
  input  logic               rs_full,
  input  logic               lsb_full,
  input  logic [ROB_BIT-1:0] rob_tail,

  output logic               rob_issue,
  output logic               rs_issue,
  output logic               lsb_issue,

  output logic [XLEN-1:0]    iss_inst,
  output logic [XLEN-1:0]    iss_pc,
  output logic [XLEN-1:0]    iss_val1,
  output logic [XLEN-1:0]    iss_val2,
  output logic               iss_has_dep1,
  output logic               iss_has_dep2,
  output logic [ROB_BIT-1:0] iss_dep1,
  output logic [ROB_BIT-1:0] iss_dep2,
  output logic [ROB_BIT-1:0] iss_rob_entry,

  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   issue_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  issue_state_e state, state_nxt;
  slot_t        slot_d, slot_q;
  logic         fire, hs, unit_full, slot_clear;

  assign slot_d = '{inst: dec_inst, pc: dec_pc, rd: dec_rd, rs1: dec_rs1,
                    rs2: dec_rs2, wr_rd: dec_wr_rd, is_mem: dec_is_mem};
  assign hs         = dec_valid && dec_ready;
  assign slot_clear = rst_in || (rdy_in && rob_clear_up);

  issue_slot u_slot (
    .clk_in (clk_in),
    .load   (hs),
    .clear  (slot_clear),
    .d      (slot_d),
    .q      (slot_q)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= EMPTY;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rob_clear_up) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        EMPTY:   if (hs) state_nxt = FULL;
        FULL:    if (fire) state_nxt = hs ? FULL : EMPTY;
        FLUSH:   state_nxt = EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: every output of this block is assigned on every pass, so no latch
  // can be inferred. Reset is folded in so nothing strobes while it is high.
  always_comb begin
    unit_full = slot_q.is_mem ? lsb_full : rs_full;
    fire      = !rst_in && (state == FULL) && rdy_in && !rob_clear_up &&
                !rob_full && !unit_full;
    dec_ready = !rst_in && rdy_in && !rob_clear_up && ((state == EMPTY) || fire);

    rob_issue     = fire;
    rs_issue      = fire && !slot_q.is_mem;
    lsb_issue     = fire && slot_q.is_mem;
    rob_issue_reg = fire && slot_q.wr_rd && (slot_q.rd != '0);
    issue_reg_id  = rob_issue_reg ? slot_q.rd : '0;

    get_id1 = (!rst_in && state == FULL) ? slot_q.rs1 : '0;
    get_id2 = (!rst_in && state == FULL) ? slot_q.rs2 : '0;

    issue_rob_entry = rob_tail;
    iss_rob_entry   = rob_tail;
    iss_inst        = slot_q.inst;
    iss_pc          = slot_q.pc;
    iss_val1        = val1;
    iss_val2        = val2;
    iss_has_dep1    = has_dep1;
    iss_has_dep2    = has_dep2;
    iss_dep1        = dep1;
    iss_dep2        = dep2;
  end

  // Counters survive flushes; only reset clears them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (rdy_in) begin
      if ((state == FULL) && !fire && !rob_clear_up && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (fire && (issue_cnt != CNT_MAX)) begin
        issue_cnt <= issue_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus random traffic,
// all checked each cycle against a queue-based model of the issue stage.
module tb_issue_ctrl;

  localparam int RB    = issue_ctrl_pkg::ROB_BIT;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rob_clear_up;
  logic          dec_valid, dec_ready;
  logic [31:0]   dec_inst, dec_pc;
  logic [4:0]    dec_rd, dec_rs1, dec_rs2;
  logic          dec_wr_rd, dec_is_mem;
  logic [4:0]    get_id1, get_id2;
  logic [31:0]   val1, val2;
  logic          has_dep1, has_dep2;
  logic [RB-1:0] dep1, dep2;
  logic          rob_issue_reg;
  logic [4:0]    issue_reg_id;
  logic [RB-1:0] issue_rob_entry;
  logic          rob_full, rs_full, lsb_full;
  logic [RB-1:0] rob_tail;
  logic          rob_issue, rs_issue, lsb_issue;
  logic [31:0]   iss_inst, iss_pc, iss_val1, iss_val2;
  logic          iss_has_dep1, iss_has_dep2;
  logic [RB-1:0] iss_dep1, iss_dep2, iss_rob_entry;
  logic [CNT_W-1:0] stall_cnt, issue_cnt;

  issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_wr_rd(dec_wr_rd), .dec_is_mem(dec_is_mem),
    .get_id1(get_id1), .get_id2(get_id2), .val1(val1), .val2(val2),
    .has_dep1(has_dep1), .has_dep2(has_dep2), .dep1(dep1), .dep2(dep2),
    .rob_issue_reg(rob_issue_reg), .issue_reg_id(issue_reg_id),
    .issue_rob_entry(issue_rob_entry),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tail(rob_tail),
    .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
    .iss_inst(iss_inst), .iss_pc(iss_pc), .iss_val1(iss_val1), .iss_val2(iss_val2),
    .iss_has_dep1(iss_has_dep1), .iss_has_dep2(iss_has_dep2),
    .iss_dep1(iss_dep1), .iss_dep2(iss_dep2), .iss_rob_entry(iss_rob_entry),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst, pc;
    logic [4:0]  rd, rs1, rs2;
    bit          wr, mem;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [RB-1:0] tail;
    logic        reg_wr, lsb, rs;
  } fired_t;

  // Model: the slot is a queue of at most one instruction plus a flush flag.
  instr_t held[$];
  bit     flushing;
  int     m_stall, m_issue;
  bit     e_fire, e_ready;
  fired_t fired[$];
  int     cyc, n_vec, n_err;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    bit     full, empty, ufull, e_reg;
    instr_t h;
    full  = (held.size() == 1);
    empty = !full && !flushing;
    h     = '{inst: 0, pc: 0, rd: 0, rs1: 0, rs2: 0, wr: 0, mem: 0};
    if (full) h = held[0];
    ufull   = h.mem ? lsb_full : rs_full;
    e_fire  = !rst_in && full && rdy_in && !rob_clear_up && !rob_full && !ufull;
    e_ready = !rst_in && rdy_in && !rob_clear_up && (empty || e_fire);
    e_reg   = e_fire && h.wr && (h.rd != 0);

    check("dec_ready",       dec_ready,       e_ready);
    check("rob_issue",       rob_issue,       e_fire);
    check("rs_issue",        rs_issue,        e_fire && !h.mem);
    check("lsb_issue",       lsb_issue,       e_fire && h.mem);
    check("rob_issue_reg",   rob_issue_reg,   e_reg);
    check("issue_reg_id",    issue_reg_id,    e_reg ? h.rd : 5'd0);
    check("issue_rob_entry", issue_rob_entry, rob_tail);
    check("iss_rob_entry",   iss_rob_entry,   rob_tail);
    check("get_id1",         get_id1,         (full && !rst_in) ? h.rs1 : 5'd0);
    check("get_id2",         get_id2,         (full && !rst_in) ? h.rs2 : 5'd0);
    check("iss_val1",        iss_val1,        val1);
    check("iss_dep2",        iss_dep2,        dep2);
    check("iss_has_dep1",    iss_has_dep1,    has_dep1);
    check("stall_cnt",       stall_cnt,       m_stall);
    check("issue_cnt",       issue_cnt,       m_issue);
    if (e_fire) begin
      check("iss_inst", iss_inst, h.inst);
      check("iss_pc",   iss_pc,   h.pc);
    end
    if (rob_issue === 1'b1)
      fired.push_back('{cyc: cyc, rd: issue_reg_id, tail: issue_rob_entry,
                        reg_wr: rob_issue_reg, lsb: lsb_issue, rs: rs_issue});
  endtask

  task automatic update();
    instr_t n;
    if (rst_in) begin
      held.delete();
      flushing = 0;
      m_stall  = 0;
      m_issue  = 0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        held.delete();
        flushing = 1;
      end else begin
        if (held.size() == 1 && !e_fire && m_stall < CMAX) m_stall++;
        if (e_fire) begin
          void'(held.pop_front());
          if (m_issue < CMAX) m_issue++;
        end
        if (dec_valid && e_ready) begin
          n = '{inst: dec_inst, pc: dec_pc, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                wr: dec_wr_rd, mem: dec_is_mem};
          held.push_back(n);
        end
        flushing = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    compare();
    @(posedge clk_in);
    update();
    #1;
    cyc++;
  endtask

  task automatic set_instr(input logic [4:0] rd, input bit wr, input bit mem);
    dec_rd     = rd;
    dec_wr_rd  = wr;
    dec_is_mem = mem;
    dec_rs1    = rd + 5'd1;
    dec_rs2    = rd + 5'd2;
    dec_inst   = {27'h123_4567, rd};
    dec_pc     = 32'h1000 + {27'd0, rd};
  endtask

  int base_s, base_i;

  initial begin
    rst_in = 1; rdy_in = 1; rob_clear_up = 0; dec_valid = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rob_tail = '0;
    val1 = 32'hAAAA_0001; val2 = 32'h5555_0002; has_dep1 = 1; has_dep2 = 0;
    dep1 = RB'(3); dep2 = RB'(5);
    set_instr(5'd0, 0, 0);
    tick(); tick();
    rst_in = 0;

    // Back-to-back ALU issue, rd 5/6/7 against rob_tail 2/3/4.
    fired.delete();
    set_instr(5'd5, 1, 0); dec_valid = 1; rob_tail = RB'(1); tick();
    set_instr(5'd6, 1, 0); rob_tail = RB'(2); tick();
    set_instr(5'd7, 1, 0); rob_tail = RB'(3); tick();
    dec_valid = 0; rob_tail = RB'(4); tick();
    check("b2b_count", fired.size(), 3);
    if (fired.size() == 3) begin
      check("b2b_rd0", fired[0].rd, 5); check("b2b_rd1", fired[1].rd, 6);
      check("b2b_rd2", fired[2].rd, 7);
      check("b2b_tail0", fired[0].tail, 2); check("b2b_tail2", fired[2].tail, 4);
      check("b2b_consecutive", fired[2].cyc - fired[0].cyc, 2);
    end

    // Reservation station full for four cycles.
    set_instr(5'd8, 1, 0); dec_valid = 1; rs_full = 1; tick();
    dec_valid = 0; base_s = stall_cnt;
    fired.delete();
    repeat (4) tick();
    check("stall_delta", stall_cnt - base_s[CNT_W-1:0], 4);
    check("stall_no_fire", fired.size(), 0);
    rs_full = 0; tick();
    check("stall_fire", fired.size(), 1);

    // Memory op routes to LSB while RS is full.
    set_instr(5'd9, 1, 1); dec_valid = 1; rs_full = 1; tick();
    dec_valid = 0; fired.delete(); tick();
    check("mem_fire", fired.size(), 1);
    if (fired.size() == 1) begin
      check("mem_lsb", fired[0].lsb, 1); check("mem_rs", fired[0].rs, 0);
    end
    rs_full = 0;

    // Destination x0 never renames.
    set_instr(5'd0, 1, 0); dec_valid = 1; tick();
    dec_valid = 0; fired.delete(); tick();
    check("x0_fire", fired.size(), 1);
    if (fired.size() == 1) begin
      check("x0_reg", fired[0].reg_wr, 0); check("x0_id", fired[0].rd, 0);
    end

    // Flush while stalled on a full ROB.
    set_instr(5'd3, 1, 0); dec_valid = 1; rob_full = 1; tick();
    dec_valid = 0; tick();
    fired.delete();
    rob_clear_up = 1; tick();
    rob_clear_up = 0; rob_full = 0; set_instr(5'd4, 1, 0); dec_valid = 1; tick();
    tick();
    dec_valid = 0; tick();
    check("flush_fired", fired.size(), 1);
    if (fired.size() == 1) check("flush_new_rd", fired[0].rd, 4);

    // rdy_in low freezes everything, even a flush request.
    set_instr(5'd10, 1, 0); dec_valid = 1; tick();
    dec_valid = 0; rdy_in = 0; fired.delete();
    base_s = stall_cnt; base_i = issue_cnt;
    tick(); rob_clear_up = 1; tick(); rob_clear_up = 0; tick();
    check("rdy_stall_hold", stall_cnt, base_s);
    check("rdy_issue_hold", issue_cnt, base_i);
    check("rdy_no_fire", fired.size(), 0);
    rdy_in = 1; tick();
    check("rdy_fire", fired.size(), 1);

    // Reset while an instruction is ready to issue.
    set_instr(5'd11, 1, 0); dec_valid = 1; tick();
    dec_valid = 0; rst_in = 1; fired.delete(); tick();
    rst_in = 0; tick(); tick();
    check("rst_drop", fired.size(), 0);

    // Stall counter saturation.
    set_instr(5'd12, 1, 0); dec_valid = 1; rs_full = 1; tick();
    dec_valid = 0;
    repeat (CMAX + 5) tick();
    check("stall_sat", stall_cnt, CMAX);
    rs_full = 0; tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_in       = ($urandom_range(0, 59) == 0);
      rdy_in       = ($urandom_range(0, 4) != 0);
      rob_clear_up = ($urandom_range(0, 15) == 0);
      rob_full     = ($urandom_range(0, 3) == 0);
      rs_full      = ($urandom_range(0, 3) == 0);
      lsb_full     = ($urandom_range(0, 3) == 0);
      dec_valid    = ($urandom_range(0, 9) < 6);
      dec_inst     = $urandom; dec_pc = $urandom;
      dec_rd       = 5'($urandom); dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
      dec_wr_rd    = 1'($urandom); dec_is_mem = 1'($urandom);
      rob_tail     = RB'($urandom);
      val1 = $urandom; val2 = $urandom;
      has_dep1 = 1'($urandom); has_dep2 = 1'($urandom);
      dep1 = RB'($urandom); dep2 = RB'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the stall and issue performance counters; ROB_BIT is taken from the shared constants include.
REQ-002 clk_in  input  1  system clock, all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  when low, all state and counters hold and no issue strobe asserts.
REQ-005 rob_clear_up  input  1  pipeline flush from ROB.
REQ-006 dec_valid / dec_ready  input / output  1 / 1  decoder handshake; transfer when both high on a rising edge.
REQ-007 dec_inst, dec_pc  input  32 each  instruction word and PC carried to the issued entry.
REQ-008 dec_rd, dec_rs1, dec_rs2  input  5 each; dec_wr_rd, dec_is_mem  input  1 each.
REQ-009 get_id1, get_id2  output  5 each; val1, val2 input 32; has_dep1, has_dep2 input 1; dep1, dep2 input ROB_BIT: register-file read ports.
REQ-010 rob_issue_reg  output 1; issue_reg_id  output 5; issue_rob_entry  output ROB_BIT: register-file rename write.
REQ-011 rob_full, rs_full, lsb_full  input 1 each; rob_tail  input ROB_BIT, next free ROB entry.
REQ-012 rob_issue, rs_issue, lsb_issue  output 1 each, single-cycle issue strobes.
REQ-013 iss_inst, iss_pc, iss_val1, iss_val2  output 32; iss_has_dep1, iss_has_dep2  output 1; iss_dep1, iss_dep2, iss_rob_entry  output ROB_BIT: issued bundle.
REQ-014 stall_cnt, issue_cnt  output CNT_W  performance counters.

Function
REQ-015 FSM states SHALL be EMPTY, FULL, FLUSH; one-entry slot holds the decoded fields while in FULL.
REQ-016 fire = FULL && rdy_in && !rob_clear_up && !rob_full && !(dec_is_mem_held ? lsb_full : rs_full).
REQ-017 dec_ready = rdy_in && !rob_clear_up && (state==EMPTY || fire); SHALL be 0 in FLUSH.
REQ-018 Handshake in EMPTY -> FULL next cycle; fire without new handshake -> EMPTY; fire with handshake -> stays FULL with new entry (back-to-back, one instruction per cycle).
REQ-019 Issue latency: instruction accepted at edge N fires no earlier than cycle N+1; strobes and bundle combinational from slot plus register-file responses.
REQ-020 get_id1/get_id2 SHALL drive held rs1/rs2 whenever FULL, else 0; iss_val/has_dep/dep pass val/has_dep/dep through.
REQ-021 rob_issue asserts on fire; rs_issue on fire && !is_mem; lsb_issue on fire && is_mem; exactly one of rs_issue/lsb_issue with rob_issue.
REQ-022 rob_issue_reg = fire && wr_rd && rd!=0; issue_reg_id = held rd when asserted, else 0; issue_rob_entry = iss_rob_entry = rob_tail.
REQ-023 rob_clear_up (rdy_in high) from any state SHALL discard slot, suppress all strobes, and go to FLUSH; FLUSH -> EMPTY next cycle unless clear_up is still high.
REQ-024 stall_cnt increments each rdy_in cycle with FULL && !fire && !rob_clear_up; issue_cnt increments on fire; both saturate at all-ones, not reset by flush.
REQ-025 rdy_in low SHALL freeze state, slot and counters, even if rob_clear_up is high.

Reset
REQ-026 On rst_in high at a clock edge: state EMPTY, slot cleared to 0, counters 0; takes priority over rdy_in and rob_clear_up.
REQ-027 During and after reset all strobes, get_id1/2, issue_reg_id 0; dec_ready 1 in first cycle after reset with rdy_in high.
REQ-028 Reset mid-issue SHALL drop the held instruction with no strobe.

Structure
REQ-029 ROB_BIT and state encodings SHALL live in the shared constants include used by the register file and ROB.
REQ-030 The one-entry hold register SHALL be a sub-module issue_slot (load, clear, field outputs); FSM and counters in issue_ctrl.

Verification
REQ-031 Back-to-back: 3 ALU instrs rd=5,6,7, rob_tail 2,3,4, no full -> rob_issue 3 consecutive cycles, issue_reg_id 5,6,7, issue_rob_entry 2,3,4.
REQ-032 Stall: instr held, rs_full=1 for 4 cycles -> no strobes, dec_ready 0, stall_cnt +4, fire cycle after rs_full drops.
REQ-033 Mem routing: dec_is_mem=1, lsb_full=0, rs_full=1 -> lsb_issue=1, rs_issue=0 same cycle as rob_issue.
REQ-034 rd=x0: dec_wr_rd=1, dec_rd=0 -> rob_issue=1, rob_issue_reg=0, issue_reg_id=0.
REQ-035 Flush: FULL with rob_full=1, rob_clear_up 1 cycle -> no strobes, FLUSH one cycle with dec_ready 0, then EMPTY, dec_ready 1.
REQ-036 rdy_in low 3 cycles in FULL with free units -> no fire, counters unchanged; fire first cycle rdy_in returns high.
